// File: rtl/up_tpl_bus_aggregator.sv
// Register-bus aggregator between up_axi and the TPL register slaves: window decode,
// one-hot request steering and bounded ack timeout on independent read/write channels.
module up_tpl_bus_aggregator #(
   parameter int                                         NUM_SLAVES = 4,
   parameter int                                         ADDR_WIDTH = 14,
   parameter int                                         SLAVE_AW   = 8,
   parameter logic [NUM_SLAVES*(ADDR_WIDTH-SLAVE_AW)-1:0] SLAVE_BASE = {6'h3, 6'h2, 6'h1, 6'h0},
   parameter int                                         TIMEOUT    = 64,
   parameter logic [31:0]                                ERR_DATA   = 32'hDEADDEAD
) (
   input  logic                     up_clk,
   input  logic                     up_rstn,
   input  logic                     up_wreq,
   input  logic [ADDR_WIDTH-1:0]    up_waddr,
   input  logic [31:0]              up_wdata,
   output logic                     up_wack,
   input  logic                     up_rreq,
   input  logic [ADDR_WIDTH-1:0]    up_raddr,
   output logic [31:0]              up_rdata,
   output logic                     up_rack,
   output logic [NUM_SLAVES-1:0]    dn_wreq,
   output logic [ADDR_WIDTH-1:0]    dn_waddr,
   output logic [31:0]              dn_wdata,
   input  logic [NUM_SLAVES-1:0]    dn_wack,
   output logic [NUM_SLAVES-1:0]    dn_rreq,
   output logic [ADDR_WIDTH-1:0]    dn_raddr,
   input  logic [NUM_SLAVES*32-1:0] dn_rdata,
   input  logic [NUM_SLAVES-1:0]    dn_rack,
   output logic [15:0]              timeout_count,
   output logic [15:0]              miss_count
);

   localparam int IDX_W = ADDR_WIDTH - SLAVE_AW;
   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   // Returns {hit, index}; scanning downwards lets the lowest matching window win.
   function automatic logic [SEL_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [SEL_W:0] r;
      r = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if (addr[ADDR_WIDTH-1:SLAVE_AW] == SLAVE_BASE[k*IDX_W +: IDX_W]) begin
            r = {1'b1, SEL_W'(k)};
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, c} + {15'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   state_e                  w_state_q, w_state_d, r_state_q, r_state_d;
   logic [SEL_W-1:0]        w_sel_q, w_sel_d, r_sel_q, r_sel_d;
   logic [15:0]             w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
   logic [NUM_SLAVES-1:0]   dn_wreq_q, dn_wreq_d, dn_rreq_q, dn_rreq_d;
   logic [ADDR_WIDTH-1:0]   dn_waddr_q, dn_waddr_d, dn_raddr_q, dn_raddr_d;
   logic [31:0]             dn_wdata_q, dn_wdata_d;
   logic                    up_wack_q, up_wack_d, up_rack_q, up_rack_d;
   logic [31:0]             up_rdata_q, up_rdata_d;
   logic [15:0]             timeout_count_q, timeout_count_d, miss_count_q, miss_count_d;
   logic                    w_miss, w_to, r_miss, r_to;
   logic [SEL_W:0]          w_dec, r_dec;

   always_comb begin
      w_state_d  = w_state_q;
      w_sel_d    = w_sel_q;
      w_cnt_d    = w_cnt_q;
      dn_wreq_d  = '0;
      dn_waddr_d = dn_waddr_q;
      dn_wdata_d = dn_wdata_q;
      up_wack_d  = 1'b0;
      w_miss     = 1'b0;
      w_to       = 1'b0;
      w_dec      = decode(up_waddr);
      case (w_state_q)
         ST_IDLE: begin
            if (up_wreq) begin
               if (w_dec[SEL_W]) begin
                  dn_wreq_d[w_dec[SEL_W-1:0]] = 1'b1;
                  dn_waddr_d = up_waddr;
                  dn_wdata_d = up_wdata;
                  w_sel_d    = w_dec[SEL_W-1:0];
                  w_cnt_d    = '0;
                  w_state_d  = ST_WAIT;
               end else begin
                  up_wack_d = 1'b1;
                  w_miss    = 1'b1;
                  w_state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            // The selected slave's ack takes priority over a timeout in the same cycle.
            if (dn_wack[w_sel_q]) begin
               up_wack_d = 1'b1;
               w_state_d = ST_IDLE;
            end else if (w_cnt_q == TO_LAST) begin
               up_wack_d = 1'b1;
               w_to      = 1'b1;
               w_state_d = ST_IDLE;
            end else begin
               w_cnt_d = w_cnt_q + 16'd1;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      r_state_d  = r_state_q;
      r_sel_d    = r_sel_q;
      r_cnt_d    = r_cnt_q;
      dn_rreq_d  = '0;
      dn_raddr_d = dn_raddr_q;
      up_rack_d  = 1'b0;
      up_rdata_d = '0;
      r_miss     = 1'b0;
      r_to       = 1'b0;
      r_dec      = decode(up_raddr);
      case (r_state_q)
         ST_IDLE: begin
            if (up_rreq) begin
               if (r_dec[SEL_W]) begin
                  dn_rreq_d[r_dec[SEL_W-1:0]] = 1'b1;
                  dn_raddr_d = up_raddr;
                  r_sel_d    = r_dec[SEL_W-1:0];
                  r_cnt_d    = '0;
                  r_state_d  = ST_WAIT;
               end else begin
                  up_rack_d = 1'b1;
                  r_miss    = 1'b1;
                  r_state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (dn_rack[r_sel_q]) begin
               up_rack_d  = 1'b1;
               up_rdata_d = dn_rdata[r_sel_q*32 +: 32];
               r_state_d  = ST_IDLE;
            end else if (r_cnt_q == TO_LAST) begin
               up_rack_d  = 1'b1;
               up_rdata_d = ERR_DATA;
               r_to       = 1'b1;
               r_state_d  = ST_IDLE;
            end else begin
               r_cnt_d = r_cnt_q + 16'd1;
            end
         end
         default: r_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      timeout_count_d = sat_add(timeout_count_q, {1'b0, w_to} + {1'b0, r_to});
      miss_count_d    = sat_add(miss_count_q, {1'b0, w_miss} + {1'b0, r_miss});
   end

   always_ff @(posedge up_clk) begin
      if (!up_rstn) begin
         w_state_q       <= ST_IDLE;
         r_state_q       <= ST_IDLE;
         w_sel_q         <= '0;
         r_sel_q         <= '0;
         w_cnt_q         <= '0;
         r_cnt_q         <= '0;
         dn_wreq_q       <= '0;
         dn_rreq_q       <= '0;
         dn_waddr_q      <= '0;
         dn_raddr_q      <= '0;
         dn_wdata_q      <= '0;
         up_wack_q       <= 1'b0;
         up_rack_q       <= 1'b0;
         up_rdata_q      <= '0;
         timeout_count_q <= '0;
         miss_count_q    <= '0;
      end else begin
         w_state_q       <= w_state_d;
         r_state_q       <= r_state_d;
         w_sel_q         <= w_sel_d;
         r_sel_q         <= r_sel_d;
         w_cnt_q         <= w_cnt_d;
         r_cnt_q         <= r_cnt_d;
         dn_wreq_q       <= dn_wreq_d;
         dn_rreq_q       <= dn_rreq_d;
         dn_waddr_q      <= dn_waddr_d;
         dn_raddr_q      <= dn_raddr_d;
         dn_wdata_q      <= dn_wdata_d;
         up_wack_q       <= up_wack_d;
         up_rack_q       <= up_rack_d;
         up_rdata_q      <= up_rdata_d;
         timeout_count_q <= timeout_count_d;
         miss_count_q    <= miss_count_d;
      end
   end

   assign up_wack       = up_wack_q;
   assign up_rack       = up_rack_q;
   assign up_rdata      = up_rdata_q;
   assign dn_wreq       = dn_wreq_q;
   assign dn_rreq       = dn_rreq_q;
   assign dn_waddr      = dn_waddr_q;
   assign dn_raddr      = dn_raddr_q;
   assign dn_wdata      = dn_wdata_q;
   assign timeout_count = timeout_count_q;
   assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_up_tpl_bus_aggregator.sv
// Directed bench for up_tpl_bus_aggregator with default parameters (4 slaves, TIMEOUT=64).
module tb_up_tpl_bus_aggregator;

   logic         up_clk = 1'b0;
   logic         up_rstn = 1'b0;
   logic         up_wreq = 1'b0;
   logic [13:0]  up_waddr = '0;
   logic [31:0]  up_wdata = '0;
   logic         up_wack;
   logic         up_rreq = 1'b0;
   logic [13:0]  up_raddr = '0;
   logic [31:0]  up_rdata;
   logic         up_rack;
   logic [3:0]   dn_wreq;
   logic [13:0]  dn_waddr;
   logic [31:0]  dn_wdata;
   logic [3:0]   dn_wack = '0;
   logic [3:0]   dn_rreq;
   logic [13:0]  dn_raddr;
   logic [127:0] dn_rdata = '0;
   logic [3:0]   dn_rack = '0;
   logic [15:0]  timeout_count;
   logic [15:0]  miss_count;

   int n_vec = 0;
   int n_err = 0;

   up_tpl_bus_aggregator dut (
      .up_clk(up_clk), .up_rstn(up_rstn),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
      .dn_wreq(dn_wreq), .dn_waddr(dn_waddr), .dn_wdata(dn_wdata), .dn_wack(dn_wack),
      .dn_rreq(dn_rreq), .dn_raddr(dn_raddr), .dn_rdata(dn_rdata), .dn_rack(dn_rack),
      .timeout_count(timeout_count), .miss_count(miss_count)
   );

   always #5 up_clk = ~up_clk;

   task automatic tick();
      @(posedge up_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wack"}, 32'(up_wack), 32'h0);
      chk({tag, "_rack"}, 32'(up_rack), 32'h0);
      chk({tag, "_rdata"}, up_rdata, 32'h0);
      chk({tag, "_dn_wreq"}, 32'(dn_wreq), 32'h0);
      chk({tag, "_dn_rreq"}, 32'(dn_rreq), 32'h0);
      chk({tag, "_dn_waddr"}, 32'(dn_waddr), 32'h0);
      chk({tag, "_dn_raddr"}, 32'(dn_raddr), 32'h0);
      chk({tag, "_dn_wdata"}, dn_wdata, 32'h0);
      chk({tag, "_to_cnt"}, 32'(timeout_count), 32'h0);
      chk({tag, "_miss_cnt"}, 32'(miss_count), 32'h0);
   endtask

   initial begin
      int n;
      logic seen;

      // Reset state
      tick();
      tick();
      chk_all_zero("rst");
      up_rstn = 1'b1;
      tick();

      // Write slave 1, ack 3 cycles after dn_wreq
      up_wreq = 1'b1; up_waddr = 14'h0105; up_wdata = 32'h12345678;
      tick();
      up_wreq = 1'b0;
      chk("w1_dn_wreq", 32'(dn_wreq), 32'h2);
      chk("w1_dn_waddr", 32'(dn_waddr), 32'h0105);
      chk("w1_dn_wdata", dn_wdata, 32'h12345678);
      tick();
      chk("w1_dn_wreq_pulse", 32'(dn_wreq), 32'h0);
      tick();
      tick();
      dn_wack = 4'b0010;
      chk("w1_wack_early", 32'(up_wack), 32'h0);
      tick();
      dn_wack = '0;
      chk("w1_wack", 32'(up_wack), 32'h1);
      tick();
      chk("w1_wack_pulse", 32'(up_wack), 32'h0);
      chk("w1_to_cnt", 32'(timeout_count), 32'h0);

      // Read slave 3, ack in same cycle as dn_rreq
      up_rreq = 1'b1; up_raddr = 14'h0310;
      tick();
      up_rreq = 1'b0;
      chk("r3_dn_rreq", 32'(dn_rreq), 32'h8);
      chk("r3_dn_raddr", 32'(dn_raddr), 32'h0310);
      chk("r3_rdata_idle", up_rdata, 32'h0);
      dn_rack = 4'b1000; dn_rdata[3*32 +: 32] = 32'hCAFEF00D;
      tick();
      dn_rack = '0; dn_rdata = '0;
      chk("r3_rack", 32'(up_rack), 32'h1);
      chk("r3_rdata", up_rdata, 32'hCAFEF00D);
      tick();
      chk("r3_rack_pulse", 32'(up_rack), 32'h0);
      chk("r3_rdata_clr", up_rdata, 32'h0);

      // Unmapped read
      up_rreq = 1'b1; up_raddr = 14'h3F00;
      tick();
      up_rreq = 1'b0;
      chk("miss_dn_rreq", 32'(dn_rreq), 32'h0);
      chk("miss_rack", 32'(up_rack), 32'h1);
      chk("miss_rdata", up_rdata, 32'h0);
      chk("miss_cnt", 32'(miss_count), 32'h1);
      tick();
      chk("miss_rack_pulse", 32'(up_rack), 32'h0);

      // Write slave 2 which never acks; foreign acks must be ignored
      up_wreq = 1'b1; up_waddr = 14'h0200; up_wdata = 32'hA5A5A5A5;
      tick();
      up_wreq = 1'b0;
      chk("to_dn_wreq", 32'(dn_wreq), 32'h4);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         if (n == 1) dn_wack = 4'b1011;
         else dn_wack = '0;
         tick();
         n++;
         seen = up_wack;
      end
      dn_wack = '0;
      chk("to_latency", 32'(n), 32'd64);
      chk("to_cnt", 32'(timeout_count), 32'h1);
      repeat (9) tick();
      dn_wack = 4'b0100;
      tick();
      dn_wack = '0;
      seen = up_wack;
      repeat (3) begin
         tick();
         seen = seen | up_wack;
      end
      chk("to_late_ack", 32'(seen), 32'h0);
      chk("to_cnt_hold", 32'(timeout_count), 32'h1);

      // Read timeout on slave 1 returns the error word
      up_rreq = 1'b1; up_raddr = 14'h0140;
      tick();
      up_rreq = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         tick();
         n++;
         seen = up_rack;
      end
      chk("rto_latency", 32'(n), 32'd64);
      chk("rto_rdata", up_rdata, 32'hDEADDEAD);
      chk("rto_cnt", 32'(timeout_count), 32'h2);
      tick();

      // Simultaneous read and write to slave 0, write acked first
      up_rreq = 1'b1; up_raddr = 14'h0004;
      up_wreq = 1'b1; up_waddr = 14'h0008; up_wdata = 32'h0BADBEEF;
      tick();
      up_rreq = 1'b0; up_wreq = 1'b0;
      chk("rw_dn_rreq", 32'(dn_rreq), 32'h1);
      chk("rw_dn_wreq", 32'(dn_wreq), 32'h1);
      chk("rw_dn_raddr", 32'(dn_raddr), 32'h0004);
      chk("rw_dn_waddr", 32'(dn_waddr), 32'h0008);
      dn_wack = 4'b0001;
      tick();
      dn_wack = '0;
      chk("rw_wack", 32'(up_wack), 32'h1);
      chk("rw_rack_early", 32'(up_rack), 32'h0);
      dn_rack = 4'b0001; dn_rdata[31:0] = 32'h11112222;
      tick();
      dn_rack = '0; dn_rdata = '0;
      chk("rw_rack", 32'(up_rack), 32'h1);
      chk("rw_rdata", up_rdata, 32'h11112222);
      chk("rw_wack_once", 32'(up_wack), 32'h0);
      tick();
      chk("rw_rack_once", 32'(up_rack), 32'h0);

      // Reset during read WAIT abandons the read
      up_rreq = 1'b1; up_raddr = 14'h0220;
      tick();
      up_rreq = 1'b0;
      chk("rr_dn_rreq", 32'(dn_rreq), 32'h4);
      tick();
      up_rstn = 1'b0;
      tick();
      up_rstn = 1'b1;
      chk_all_zero("rr");
      dn_rack = 4'b0100; dn_rdata[2*32 +: 32] = 32'h55AA55AA;
      tick();
      dn_rack = '0; dn_rdata = '0;
      seen = up_rack;
      tick();
      seen = seen | up_rack;
      chk("rr_no_rack", 32'(seen), 32'h0);
      up_rreq = 1'b1; up_raddr = 14'h0220;
      tick();
      up_rreq = 1'b0;
      chk("rr2_dn_rreq", 32'(dn_rreq), 32'h4);
      dn_rack = 4'b0100; dn_rdata[2*32 +: 32] = 32'h76543210;
      tick();
      dn_rack = '0; dn_rdata = '0;
      chk("rr2_rack", 32'(up_rack), 32'h1);
      chk("rr2_rdata", up_rdata, 32'h76543210);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/up_tpl_bus_aggregator.md
Name: up_tpl_bus_aggregator

Overview:
- Parametrised register-bus aggregator that sits between up_axi and the N register slaves of a TPL core (common, per-channel and TPL-common regmaps).
- Replaces the fixed OR-reduce and registered-ack glue with three features: address-window decode, per-slave request gating, and a bounded ack timeout.
- Responds to every upstream request exactly once, including requests to unmapped addresses and requests to hung slaves.
- Write and read channels are independent and may be in flight simultaneously.

Parameters:
- NUM_SLAVES, 4, number of downstream slaves (1..16).
- ADDR_WIDTH, 14, upstream/downstream word-address width.
- SLAVE_AW, 8, low address bits local to a slave; the index field is addr[ADDR_WIDTH-1:SLAVE_AW].
- SLAVE_BASE, {6'h3,6'h2,6'h1,6'h0}, packed index-field values; slave k owns SLAVE_BASE[k*(ADDR_WIDTH-SLAVE_AW)+:(ADDR_WIDTH-SLAVE_AW)].
- TIMEOUT, 64, cycles to wait for a slave ack after the downstream request (2..65535).
- ERR_DATA, 32'hDEADDEAD, rdata returned on a read timeout.

Ports:
- up_clk, input, 1, the single clock.
- up_rstn, input, 1, synchronous active-low reset.
- up_wreq, input, 1, write request pulse.
- up_waddr, input, ADDR_WIDTH, write address.
- up_wdata, input, 32, write data.
- up_wack, output, 1, write ack pulse.
- up_rreq, input, 1, read request pulse.
- up_raddr, input, ADDR_WIDTH, read address.
- up_rdata, output, 32, read data, valid with up_rack.
- up_rack, output, 1, read ack pulse.
- dn_wreq, output, NUM_SLAVES, one-hot write request pulse.
- dn_waddr, output, ADDR_WIDTH, registered write address, shared by all slaves.
- dn_wdata, output, 32, registered write data, shared by all slaves.
- dn_wack, input, NUM_SLAVES, slave write acks.
- dn_rreq, output, NUM_SLAVES, one-hot read request pulse.
- dn_raddr, output, ADDR_WIDTH, registered read address, shared by all slaves.
- dn_rdata, input, NUM_SLAVES*32, slave read data; slave k occupies [32k+:32].
- dn_rack, input, NUM_SLAVES, slave read acks.
- timeout_count, output, 16, saturating count of timeouts (read and write combined).
- miss_count, output, 16, saturating count of unmapped accesses.

Behaviour:
- Reset (up_rstn=0 at a rising edge): every output is 0, both FSMs go to IDLE, both counters clear. Reset asserted mid-transaction abandons it; no ack is issued for it.
- Each channel runs its own FSM with states IDLE, WAIT and RESP. The write channel is described here; the read channel is identical with r-prefixed signals.
- IDLE, request at cycle T:
  - Decode against all SLAVE_BASE entries. The lowest matching k wins if windows overlap.
  - On a hit: at T+1, dn_wreq[k]=1 for exactly one cycle, dn_waddr/dn_wdata are latched, the wait counter is set to 0, and the FSM moves to WAIT.
  - On a miss: no dn_wreq, go to RESP, up_wack=1 at T+1, miss_count+1. A read miss returns up_rdata=0.
- WAIT:
  - Only dn_wack[sel] is honoured; acks from other slaves are ignored.
  - An ack seen at cycle X gives up_wack=1 at X+1 and the FSM returns to IDLE. For reads, up_rdata is dn_rdata[sel] registered at X.
  - An ack in the same cycle as dn_wreq counts, so the minimum latency from request to up_wack is 2 cycles.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT-1 with no ack, up_wack=1 on the next cycle, timeout_count+1, and the FSM returns to IDLE. A read timeout returns up_rdata=ERR_DATA.
  - If an ack and the timeout threshold arrive in the same cycle, the ack wins and the timeout is not counted.
- RESP: a single-cycle ack state, then IDLE.
- Ack and rdata rules:
  - up_wack and up_rack are single-cycle pulses.
  - up_rdata is 0 whenever up_rack=0.
- A new request while the channel is not IDLE is dropped; up_axi guarantees this cannot happen, and the block has no queue.
- Simultaneous read and write, even to the same slave, are both forwarded in the same cycle.
- If a timeout and a miss increment in the same cycle (one on each channel), the counter advances by the sum. Counters saturate at 16'hFFFF.
- A late slave ack that arrives after a timeout, with the channel in IDLE, is ignored.

Test Plan:
- Write 0x12345678 to addr 14'h0105 with slave 1 acking 3 cycles after dn_wreq -> dn_wreq=4'b0010 for one cycle; dn_waddr=14'h0105, dn_wdata=0x12345678; up_wack exactly one cycle after the slave ack; timeout_count=0.
- Read addr 14'h0310 while slave 3 returns 0xCAFEF00D with dn_rack in the same cycle as dn_rreq -> up_rack and up_rdata=0xCAFEF00D 2 cycles after up_rreq.
- Read addr 14'h3F00 (unmapped) -> no dn_rreq; up_rack at T+1 with rdata=0; miss_count=1.
- Write to slave 2, which never acks, with TIMEOUT=64 -> up_wack 64 cycles after dn_wreq; timeout_count=1. A slave ack injected 10 cycles later produces no upstream ack.
- Read of slave 0 and write of slave 0 issued in the same cycle, acks 1 cycle apart -> both forwarded in one cycle; up_rack and up_wack are each issued once, in ack order.
- up_rstn deasserted for one cycle during a read WAIT -> no up_rack; all outputs and counters are 0; the next read completes normally.
